eros_obi_prog_demux: RTL and testbench

- Runtime-programmable OBI address demultiplexer: one OBI slave port fans out to NUM_PORTS OBI master ports using a register-programmed rule table (start/end/idx/enable) instead of fixed package constants.
- Adds an internal error responder for unmapped addresses, in-order outstanding-transaction tracking, a saturating error counter, and a one-way config lock.
- Sits in the eros system bus between a core data/instr port and the system crossbar / CPU private register region.

---
 rtl/eros_obi_prog_demux.sv | 203 ++++++++++++++++++++
 tb/tb_eros_obi_prog_demux.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eros_obi_prog_demux.sv
// eros_obi_prog_demux: runtime-programmable OBI address demultiplexer with internal error responder.
// Latency: request path is combinational (0 cycles); error responses return exactly 1 cycle after grant.
// Backpressure: s_gnt_o follows the selected port's grant; held low while the outstanding limit is
// reached or while a different target still has responses pending.
//
// Ports: s_* upstream OBI slave, m_* downstream OBI masters (shared addr/we/be/wdata,
// per-port req/gnt/rvalid/rdata), cfg_* word-addressed rule-table/CTRL/ERR_CNT register access.

package eros_obi_prog_demux_pkg;
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;
endpackage

module eros_obi_prog_demux
    import eros_obi_prog_demux_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned NUM_RULES       = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hBADACCE5),
    parameter logic [NUM_RULES-1:0]  RESET_RULE_EN = '0,
    parameter addr_map_rule_t [NUM_RULES-1:0] RESET_RULES = '0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,

    input  logic                                  s_req_i,
    output logic                                  s_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                 s_addr_i,
    input  logic                                  s_we_i,
    input  logic [DATA_WIDTH/8-1:0]               s_be_i,
    input  logic [DATA_WIDTH-1:0]                 s_wdata_i,
    output logic                                  s_rvalid_o,
    output logic [DATA_WIDTH-1:0]                 s_rdata_o,
    output logic                                  s_err_o,

    output logic [NUM_PORTS-1:0]                  m_req_o,
    input  logic [NUM_PORTS-1:0]                  m_gnt_i,
    output logic [ADDR_WIDTH-1:0]                 m_addr_o,
    output logic                                  m_we_o,
    output logic [DATA_WIDTH/8-1:0]               m_be_o,
    output logic [DATA_WIDTH-1:0]                 m_wdata_o,
    input  logic [NUM_PORTS-1:0]                  m_rvalid_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]       m_rdata_i,

    input  logic                                  cfg_we_i,
    input  logic [$clog2(NUM_RULES*4+2)-1:0]      cfg_addr_i,
    input  logic [31:0]                           cfg_wdata_i,
    output logic [31:0]                           cfg_rdata_o
);

    localparam int unsigned CW    = $clog2(NUM_RULES*4+2);
    localparam int unsigned IW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned TW    = $clog2(NUM_PORTS+1);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1);
    // Internal target index NUM_PORTS denotes the error responder.
    localparam logic [TW-1:0] ERR_TGT = TW'(NUM_PORTS);

    logic [31:0]    rule_start_q [NUM_RULES];
    logic [31:0]    rule_end_q   [NUM_RULES];
    logic [IW-1:0]  rule_idx_q   [NUM_RULES];
    logic [NUM_RULES-1:0] rule_en_q;
    logic           lock_q;
    logic [15:0]    err_cnt_q;

    logic [TW-1:0]    cur_tgt_q;
    logic [CNT_W-1:0] out_cnt_q;
    logic             err_rsp_q;

    logic [TW-1:0]    tgt;
    logic             tgt_err;
    logic             cur_err;
    logic             allowed;
    logic             port_gnt;
    logic             hs;
    logic             rsp_vld;
    logic [DATA_WIDTH-1:0] rsp_dat;

    // Request fields are shared by all ports; only req is steered.
    assign m_addr_o  = s_addr_i;
    assign m_we_o    = s_we_i;
    assign m_be_o    = s_be_i;
    assign m_wdata_o = s_wdata_i;

    // Address decode: iterate high-to-low so the lowest matching rule wins.
    // An empty range (start >= end) can never match, so it falls through to ERR naturally.
    always_comb begin
        tgt = ERR_TGT;
        for (int r = NUM_RULES-1; r >= 0; r--) begin
            if (rule_en_q[r] &&
                (s_addr_i >= rule_start_q[r][ADDR_WIDTH-1:0]) &&
                (s_addr_i <  rule_end_q[r][ADDR_WIDTH-1:0])) begin
                if (32'(rule_idx_q[r]) < 32'(NUM_PORTS)) begin
                    tgt = TW'(rule_idx_q[r]);
                end else begin
                    tgt = ERR_TGT;
                end
            end
        end
    end

    assign tgt_err = (tgt == ERR_TGT);
    assign cur_err = (cur_tgt_q == ERR_TGT);

    // Target may only change once every in-flight response has returned, which keeps
    // responses in order. A response in this cycle does not free a slot.
    assign allowed = ((out_cnt_q == '0) || (tgt == cur_tgt_q)) &&
                     (out_cnt_q < CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        m_req_o  = '0;
        port_gnt = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (tgt == TW'(p)) begin
                m_req_o[p] = s_req_i & allowed;
                port_gnt   = m_gnt_i[p];
            end
        end
        s_gnt_o = tgt_err ? (s_req_i & allowed) : (s_req_i & allowed & port_gnt);
    end

    assign hs = s_req_i & s_gnt_o;

    // Response mux: only the port currently being tracked may answer.
    always_comb begin
        rsp_vld = 1'b0;
        rsp_dat = '0;
        if (cur_err) begin
            rsp_vld = err_rsp_q;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (cur_tgt_q == TW'(p)) begin
                    rsp_vld = m_rvalid_i[p] & (out_cnt_q != '0);
                    rsp_dat = m_rdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign s_rvalid_o = rsp_vld;
    assign s_err_o    = rsp_vld & cur_err;
    assign s_rdata_o  = !rsp_vld ? '0 : (cur_err ? ERR_RDATA : rsp_dat);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_RULES; r++) begin
                rule_start_q[r] <= RESET_RULES[r].start_addr;
                rule_end_q[r]   <= RESET_RULES[r].end_addr;
                rule_idx_q[r]   <= RESET_RULES[r].idx[IW-1:0];
            end
            rule_en_q <= RESET_RULE_EN;
            lock_q    <= 1'b0;
            err_cnt_q <= '0;
            cur_tgt_q <= '0;
            out_cnt_q <= '0;
            err_rsp_q <= 1'b0;
        end else begin
            err_rsp_q <= hs & tgt_err;
            if (hs) begin
                cur_tgt_q <= tgt;
            end
            if (hs && !rsp_vld) begin
                out_cnt_q <= out_cnt_q + CNT_W'(1);
            end else if (!hs && rsp_vld) begin
                out_cnt_q <= out_cnt_q - CNT_W'(1);
            end
            if (rsp_vld && cur_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end

            if (cfg_we_i && !lock_q) begin
                for (int r = 0; r < NUM_RULES; r++) begin
                    if (cfg_addr_i == CW'(4*r))   rule_start_q[r] <= cfg_wdata_i;
                    if (cfg_addr_i == CW'(4*r+1)) rule_end_q[r]   <= cfg_wdata_i;
                    if (cfg_addr_i == CW'(4*r+2)) rule_idx_q[r]   <= cfg_wdata_i[IW-1:0];
                    if (cfg_addr_i == CW'(4*r+3)) rule_en_q[r]    <= cfg_wdata_i[0];
                end
                // Lock is write-1-to-set; only reset clears it.
                if ((cfg_addr_i == CW'(4*NUM_RULES)) && cfg_wdata_i[0]) begin
                    lock_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        for (int r = 0; r < NUM_RULES; r++) begin
            if (cfg_addr_i == CW'(4*r))   cfg_rdata_o = rule_start_q[r];
            if (cfg_addr_i == CW'(4*r+1)) cfg_rdata_o = rule_end_q[r];
            if (cfg_addr_i == CW'(4*r+2)) cfg_rdata_o = 32'(rule_idx_q[r]);
            if (cfg_addr_i == CW'(4*r+3)) cfg_rdata_o = {31'b0, rule_en_q[r]};
        end
        if (cfg_addr_i == CW'(4*NUM_RULES))   cfg_rdata_o = {31'b0, lock_q};
        if (cfg_addr_i == CW'(4*NUM_RULES+1)) cfg_rdata_o = {16'b0, err_cnt_q};
    end

endmodule

// File: tb/tb_eros_obi_prog_demux.sv
// Directed bench for eros_obi_prog_demux: rule programming, priority, error responder,
// outstanding limit, ordered target switch, config lock and synchronous reset.
module tb_eros_obi_prog_demux;
    import eros_obi_prog_demux_pkg::*;

    localparam addr_map_rule_t R_ZERO = '{idx: 32'd0, start_addr: 32'h0, end_addr: 32'h0};
    localparam addr_map_rule_t R_THREE = '{idx: 32'd0, start_addr: 32'h0000_1000, end_addr: 32'h0000_2000};
    localparam addr_map_rule_t [3:0] RST_RULES = {R_THREE, R_ZERO, R_ZERO, R_ZERO};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_req = 1'b0;
    logic         s_gnt;
    logic [31:0]  s_addr = '0;
    logic         s_we = 1'b0;
    logic [3:0]   s_be = 4'hF;
    logic [31:0]  s_wdata = 32'h0;
    logic         s_rvalid;
    logic [31:0]  s_rdata;
    logic         s_err;
    logic [3:0]   m_req;
    logic [3:0]   m_gnt = '0;
    logic [31:0]  m_addr;
    logic         m_we;
    logic [3:0]   m_be;
    logic [31:0]  m_wdata;
    logic [3:0]   m_rvalid = '0;
    logic [127:0] m_rdata = '0;
    logic         cfg_we = 1'b0;
    logic [4:0]   cfg_addr = '0;
    logic [31:0]  cfg_wdata = '0;
    logic [31:0]  cfg_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eros_obi_prog_demux #(
        .NUM_PORTS(4), .NUM_RULES(4), .MAX_OUTSTANDING(2),
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_RDATA(32'hBADACCE5),
        .RESET_RULE_EN(4'b1000), .RESET_RULES(RST_RULES)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_req_i(s_req), .s_gnt_o(s_gnt), .s_addr_i(s_addr), .s_we_i(s_we),
        .s_be_i(s_be), .s_wdata_i(s_wdata), .s_rvalid_o(s_rvalid), .s_rdata_o(s_rdata),
        .s_err_o(s_err),
        .m_req_o(m_req), .m_gnt_i(m_gnt), .m_addr_o(m_addr), .m_we_o(m_we), .m_be_o(m_be),
        .m_wdata_o(m_wdata), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata),
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata)
    );

    // Called at a negedge; the write lands on the following posedge, returns at the next negedge.
    task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (s_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b exp 0", s_gnt); end
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b exp 0", s_rvalid); end
        checks++; if (s_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", s_rdata); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", s_err); end
        checks++; if (m_req !== 4'b0000) begin errors++; $display("FAIL reset_mreq: got %b exp 0000", m_req); end
        cfg_addr = 5'd12; #1;
        checks++; if (cfg_rdata !== 32'h0000_1000) begin errors++; $display("FAIL reset_rule3_start: got %h exp 00001000", cfg_rdata); end
        cfg_addr = 5'd15; #1;
        checks++; if (cfg_rdata !== 32'h1) begin errors++; $display("FAIL reset_rule3_en: got %h exp 1", cfg_rdata); end
        cfg_addr = 5'd17; #1;
        checks++; if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL reset_errcnt: got %h exp 0", cfg_rdata); end
        s_req = 1'b1; s_addr = 32'h0000_1800; #1;
        checks++; if (m_req !== 4'b0001) begin errors++; $display("FAIL reset_rule3_route: got %b exp 0001", m_req); end
        s_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        cfg_write(5'd8,  32'h1901_0000);
        cfg_write(5'd9,  32'h1901_2000);
        cfg_write(5'd10, 32'h0000_0001);
        cfg_write(5'd11, 32'h0000_0001);
        cfg_addr = 5'd9; #1;
        checks++; if (cfg_rdata !== 32'h1901_2000) begin errors++; $display("FAIL basic_rd_end: got %h exp 19012000", cfg_rdata); end
        s_req = 1'b1; s_addr = 32'h1901_0004; m_gnt = 4'b0010; #1;
        checks++; if (m_req !== 4'b0010) begin errors++; $display("FAIL basic_mreq: got %b exp 0010", m_req); end
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL basic_gnt: got %b exp 1", s_gnt); end
        checks++; if (m_addr !== 32'h1901_0004) begin errors++; $display("FAIL basic_maddr: got %h exp 19010004", m_addr); end
        @(negedge clk);
        s_req = 1'b0; m_gnt = 4'b0000; m_rvalid = 4'b0010; m_rdata[32 +: 32] = 32'h1234_5678; #1;
        checks++; if (s_rvalid !== 1'b1) begin errors++; $display("FAIL basic_rvalid: got %b exp 1", s_rvalid); end
        checks++; if (s_rdata !== 32'h1234_5678) begin errors++; $display("FAIL basic_rdata: got %h exp 12345678", s_rdata); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b exp 0", s_err); end
        @(negedge clk);
        m_rvalid = 4'b0000; #1;
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL basic_rvalid_clr: got %b exp 0", s_rvalid); end
    endtask

    task automatic test_overlap;
        cfg_write(5'd0, 32'h1902_0000);
        cfg_write(5'd1, 32'h1903_0000);
        cfg_write(5'd2, 32'd2);
        cfg_write(5'd3, 32'd1);
        cfg_write(5'd4, 32'h1902_0000);
        cfg_write(5'd5, 32'h1904_0000);
        cfg_write(5'd6, 32'd3);
        cfg_write(5'd7, 32'd1);
        s_req = 1'b1; s_addr = 32'h1902_0000; #1;
        checks++; if (m_req !== 4'b0100) begin errors++; $display("FAIL overlap_prio: got %b exp 0100", m_req); end
        checks++; if (s_gnt !== 1'b0) begin errors++; $display("FAIL overlap_nogrant: got %b exp 0", s_gnt); end
        s_req = 1'b0;
        cfg_write(5'd3, 32'd0);
        s_req = 1'b1; #1;
        checks++; if (m_req !== 4'b1000) begin errors++; $display("FAIL overlap_disabled: got %b exp 1000", m_req); end
        s_addr = 32'h1903_FFFF; #1;
        checks++; if (m_req !== 4'b1000) begin errors++; $display("FAIL overlap_end_minus1: got %b exp 1000", m_req); end
        s_addr = 32'h1904_0000; #1;
        checks++; if (m_req !== 4'b0000) begin errors++; $display("FAIL overlap_end_excl: got %b exp 0000", m_req); end
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL overlap_end_errgnt: got %b exp 1", s_gnt); end
        s_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_err;
        s_req = 1'b1; s_addr = 32'h0000_0010; #1;
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL err_gnt: got %b exp 1", s_gnt); end
        checks++; if (m_req !== 4'b0000) begin errors++; $display("FAIL err_mreq: got %b exp 0000", m_req); end
        @(negedge clk);
        s_req = 1'b0; #1;
        checks++; if (s_rvalid !== 1'b1) begin errors++; $display("FAIL err_rvalid: got %b exp 1", s_rvalid); end
        checks++; if (s_rdata !== 32'hBADA_CCE5) begin errors++; $display("FAIL err_rdata: got %h exp badacce5", s_rdata); end
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b exp 1", s_err); end
        @(negedge clk);
        #1;
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL err_single_rsp: got %b exp 0", s_rvalid); end
        cfg_addr = 5'd17; #1;
        checks++; if (cfg_rdata !== 32'd1) begin errors++; $display("FAIL err_cnt1: got %h exp 1", cfg_rdata); end
        s_req = 1'b1;
        repeat (65539) @(negedge clk);
        s_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (cfg_rdata !== 32'h0000_FFFF) begin errors++; $display("FAIL err_cnt_sat: got %h exp 0000ffff", cfg_rdata); end
        cfg_write(5'd17, 32'h0);
        cfg_addr = 5'd17; #1;
        checks++; if (cfg_rdata !== 32'h0000_FFFF) begin errors++; $display("FAIL err_cnt_ro: got %h exp 0000ffff", cfg_rdata); end
        @(negedge clk);
    endtask

    task automatic test_outstanding;
        s_req = 1'b1; s_addr = 32'h1901_0000; m_gnt = 4'b0010; #1;
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL out_gnt1: got %b exp 1", s_gnt); end
        @(negedge clk); #1;
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL out_gnt2: got %b exp 1", s_gnt); end
        @(negedge clk); #1;
        checks++; if (s_gnt !== 1'b0) begin errors++; $display("FAIL out_gnt3_held: got %b exp 0", s_gnt); end
        checks++; if (m_req !== 4'b0000) begin errors++; $display("FAIL out_mreq_held: got %b exp 0000", m_req); end
        @(negedge clk);
        m_rvalid = 4'b0010; m_rdata[32 +: 32] = 32'hAAAA_0001; #1;
        checks++; if (s_rvalid !== 1'b1) begin errors++; $display("FAIL out_rvalid: got %b exp 1", s_rvalid); end
        checks++; if (s_rdata !== 32'hAAAA_0001) begin errors++; $display("FAIL out_rdata: got %h exp aaaa0001", s_rdata); end
        checks++; if (s_gnt !== 1'b0) begin errors++; $display("FAIL out_rsp_no_free: got %b exp 0", s_gnt); end
        @(negedge clk);
        m_rvalid = 4'b0000; #1;
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL out_gnt3_go: got %b exp 1", s_gnt); end
        @(negedge clk);
        s_req = 1'b0; m_gnt = 4'b0000; m_rvalid = 4'b0010;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL out_stray_idle: got %b exp 0", s_rvalid); end
        m_rvalid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_target_switch;
        cfg_write(5'd3, 32'd1);
        s_req = 1'b1; s_addr = 32'h1901_0000; m_gnt = 4'b0110; #1;
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL sw_gnt_p1: got %b exp 1", s_gnt); end
        @(negedge clk);
        s_addr = 32'h1902_0000; m_rvalid = 4'b1000; #1;
        checks++; if (m_req !== 4'b0000) begin errors++; $display("FAIL sw_mreq_blocked: got %b exp 0000", m_req); end
        checks++; if (s_gnt !== 1'b0) begin errors++; $display("FAIL sw_gnt_blocked: got %b exp 0", s_gnt); end
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL sw_other_port_rvalid: got %b exp 0", s_rvalid); end
        @(negedge clk);
        m_rvalid = 4'b0010; #1;
        checks++; if (s_rvalid !== 1'b1) begin errors++; $display("FAIL sw_p1_rsp: got %b exp 1", s_rvalid); end
        checks++; if (m_req !== 4'b0000) begin errors++; $display("FAIL sw_mreq_rsp_cycle: got %b exp 0000", m_req); end
        @(negedge clk);
        m_rvalid = 4'b0000; #1;
        checks++; if (m_req !== 4'b0100) begin errors++; $display("FAIL sw_mreq_p2: got %b exp 0100", m_req); end
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL sw_gnt_p2: got %b exp 1", s_gnt); end
        @(negedge clk);
        s_req = 1'b0; m_gnt = 4'b0000; m_rvalid = 4'b0100; m_rdata[64 +: 32] = 32'hCAFE_0002; #1;
        checks++; if (s_rdata !== 32'hCAFE_0002) begin errors++; $display("FAIL sw_p2_rdata: got %h exp cafe0002", s_rdata); end
        @(negedge clk);
        m_rvalid = 4'b0000;
    endtask

    task automatic test_lock_reset;
        cfg_write(5'd16, 32'd1);
        cfg_addr = 5'd16; #1;
        checks++; if (cfg_rdata !== 32'd1) begin errors++; $display("FAIL lock_set: got %h exp 1", cfg_rdata); end
        cfg_write(5'd0, 32'h0);
        cfg_addr = 5'd0; #1;
        checks++; if (cfg_rdata !== 32'h1902_0000) begin errors++; $display("FAIL lock_ignored: got %h exp 19020000", cfg_rdata); end
        s_req = 1'b1; s_addr = 32'h1901_0000; m_gnt = 4'b0010;
        @(negedge clk);
        s_req = 1'b0; m_gnt = 4'b0000; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; m_rvalid = 4'b0010; #1;
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL rst_stray_rvalid: got %b exp 0", s_rvalid); end
        cfg_addr = 5'd16; #1;
        checks++; if (cfg_rdata !== 32'd0) begin errors++; $display("FAIL rst_lock_clr: got %h exp 0", cfg_rdata); end
        cfg_addr = 5'd0; #1;
        checks++; if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL rst_rule0_start: got %h exp 0", cfg_rdata); end
        cfg_addr = 5'd7; #1;
        checks++; if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL rst_rule1_en: got %h exp 0", cfg_rdata); end
        cfg_addr = 5'd12; #1;
        checks++; if (cfg_rdata !== 32'h0000_1000) begin errors++; $display("FAIL rst_rule3_start: got %h exp 00001000", cfg_rdata); end
        cfg_addr = 5'd17; #1;
        checks++; if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL rst_errcnt: got %h exp 0", cfg_rdata); end
        m_rvalid = 4'b0000;
        @(negedge clk);
        cfg_write(5'd0, 32'd5);
        cfg_addr = 5'd0; #1;
        checks++; if (cfg_rdata !== 32'd5) begin errors++; $display("FAIL rst_write_after_unlock: got %h exp 5", cfg_rdata); end
        cfg_addr = 5'd18; #1;
        checks++; if (cfg_rdata !== 32'd0) begin errors++; $display("FAIL unmapped_word: got %h exp 0", cfg_rdata); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_err();
        test_outstanding();
        test_target_switch();
        test_lock_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
